// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default geometry
// and the constant log2 used to size pointers and the occupancy counter.
package fifo_pkg;

   localparam int FIFO_DEF_DATA_W = 32'sd8;
   localparam int FIFO_DEF_DEPTH  = 32'sd16;

   // Ceiling log2, evaluated at elaboration time.
   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      for (int i = 32'sd0; i < 32'sd31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 32'sd1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// synchronous read port whose output register loads only on a read enable.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter  int DATA_W = FIFO_DEF_DATA_W,
   parameter  int DEPTH  = FIFO_DEF_DEPTH,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read register holds its last value whenever no read is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// overflow/underflow and a synchronous flush (clr) that outranks wr and rd.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter  int DATA_W   = FIFO_DEF_DATA_W,
   parameter  int DEPTH    = FIFO_DEF_DEPTH,
   parameter  int AF_LEVEL = DEPTH - 32'sd2,
   parameter  int AE_LEVEL = 32'sd2,
   localparam int ADDR_W   = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr,
   input  logic [DATA_W-1:0] din,
   input  logic              rd,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   if (DATA_W < 32'sd1 || DEPTH < 32'sd4 || (DEPTH & (DEPTH - 32'sd1)) != 32'sd0 ||
       !(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_params
      $error("fifo_sync_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
   end

   localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   AF_CNT    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0]   AE_CNT    = AE_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] wptr_r;
   logic [ADDR_W-1:0] rptr_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W:0]   count_nxt_s;
   logic              wr_ok_s;
   logic              rd_ok_s;
   logic              full_s;
   logic              empty_s;
   logic              overflow_r;
   logic              underflow_r;
   logic              dout_valid_r;

   // Flags decode only the registered count, never the request inputs.
   assign empty_s      = (count_r == '0);
   assign full_s       = (count_r == DEPTH_CNT);
   assign empty        = empty_s;
   assign full         = full_s;
   assign almost_empty = (count_r <= AE_CNT);
   assign almost_full  = (count_r >= AF_CNT);
   assign count        = count_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;
   assign dout_valid   = dout_valid_r;

   // Request acceptance and occupancy update.
   always_comb begin
      wr_ok_s     = 1'b0;
      rd_ok_s     = 1'b0;
      count_nxt_s = count_r;
      if (clr) begin
         count_nxt_s = '0;
      end else begin
         wr_ok_s = wr && !full_s;
         rd_ok_s = rd && !empty_s;
         case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Pointers, count, read-valid pulse and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r       <= '0;
         rptr_r       <= '0;
         count_r      <= '0;
         overflow_r   <= 1'b0;
         underflow_r  <= 1'b0;
         dout_valid_r <= 1'b0;
      end else if (clr) begin
         wptr_r       <= '0;
         rptr_r       <= '0;
         count_r      <= '0;
         overflow_r   <= 1'b0;
         underflow_r  <= 1'b0;
         dout_valid_r <= 1'b0;
      end else begin
         count_r      <= count_nxt_s;
         dout_valid_r <= rd_ok_s;
         if (wr_ok_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (rd_ok_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
         if (wr && full_s) begin
            overflow_r <= 1'b1;
         end
         if (rd && empty_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok_s),
      .waddr (wptr_r),
      .wdata (din),
      .re    (rd_ok_s),
      .raddr (rptr_r),
      .rdata (dout)
   );

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock synchronous FIFO, successor to the fixed 8-bit × 16 FIFO. It adds configurable width and depth, same-cycle read and write, programmable almost-full and almost-empty flags, an occupancy count, and sticky overflow/underflow error flags with a synchronous flush. It sits between producer and consumer blocks in the same clock domain, for example between the UART receiver and the command parser.

## Interface
Parameters:
- `DATA_W`, default 8: data width in bits, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥4.
- `AF_LEVEL`, default `DEPTH-2`: `almost_full` asserts when count ≥ `AF_LEVEL`.
- `AE_LEVEL`, default 2: `almost_empty` asserts when count ≤ `AE_LEVEL`.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous flush; empties the FIFO and clears the error flags.
- `wr` in 1: write request.
- `din` in `DATA_W`: write data.
- `rd` in 1: read request.
- `dout` out `DATA_W`: read data, registered.
- `dout_valid` out 1: `dout` holds newly read data this cycle.
- `empty` out 1: count == 0.
- `full` out 1: count == `DEPTH`.
- `almost_empty` out 1: count ≤ `AE_LEVEL`.
- `almost_full` out 1: count ≥ `AF_LEVEL`.
- `count` out `ADDR_W+1`: current occupancy, 0..`DEPTH`.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- `ADDR_W = clog2(DEPTH)`.
- `wptr` and `rptr` are `ADDR_W` bits wide and wrap naturally from `DEPTH-1` to 0.
- The count register is `ADDR_W+1` bits wide.
- Write is accepted when `wr && !full`. On acceptance, `mem[wptr] <= din` and `wptr` increments.
- Read is accepted when `rd && !empty`. On acceptance, `dout <= mem[rptr]`, `rptr` increments, and `dout_valid` pulses for one cycle.
- `full` and `empty` use the registered count from the start of the cycle.
  - Full with `wr && rd`: the read is accepted and the write is rejected; `overflow` sets.
  - Empty with `wr && rd`: the write is accepted and the read is rejected; `underflow` sets. The data is not bypassed.
- Both accepted in the same cycle: count is unchanged and both pointers advance.
- Count update: +1 if only the write is accepted, −1 if only the read is accepted, otherwise unchanged.
- `overflow` sets on `wr && full`. `underflow` sets on `rd && empty`. Both hold until `clr` or reset.
- `clr` has priority over `wr` and `rd`. In the cycle it is asserted:
  - pointers, count and the sticky flags go to 0;
  - no write or read is accepted;
  - `dout` holds its value and `dout_valid` = 0.
- All status flags are combinational decodes of the count register; there is no glitch path from `wr`, `rd` or `din`.
- Memory contents are not reset. Reads can only return entries that were written.

## Timing
- Reset values while `rst_n` = 0, applied asynchronously:
  - `wptr`, `rptr`, count = 0;
  - `dout` = 0, `dout_valid` = 0;
  - `overflow` = 0, `underflow` = 0;
  - resulting flags: `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0.
- Reset deassertion is synchronised externally. The first request is honoured on the first rising edge with `rst_n` = 1.
- Write to flag latency: `empty` falls and count increments on the edge that accepts the write.
- Read latency: data appears on `dout` one cycle after the edge where `rd` is sampled with `!empty`, with `dout_valid` high in that same cycle.
- Write-to-read latency: a word written at edge N can first be requested at edge N+1 and appears on `dout` after edge N+1.
- Back-to-back reads give one word per cycle. Sustained simultaneous read/write at any fill level from 1 to `DEPTH-1` gives full throughput.
- Reset mid-operation discards all contents. There is no partial state after reset.

## Structure
- Shared package `fifo_pkg` holds:
  - a `clog2` constant function;
  - default parameter constants `FIFO_DEF_DATA_W` = 8 and `FIFO_DEF_DEPTH` = 16.
- One sub-module, `fifo_mem`: a `DEPTH` × `DATA_W` register array with one synchronous write port and one synchronous read port carrying a registered output and a read enable.
- Pointers, count, flags and sticky error logic live in the top module.
- Elaboration checks: `DEPTH` must be a power of two and `AE_LEVEL < AF_LEVEL ≤ DEPTH`.

## Test plan
- **Reset and idle:** assert `rst_n` = 0 mid-stream after 5 writes → `empty` = 1, count = 0, `dout` = 0, `dout_valid` = 0 immediately, without waiting for a clock edge.
- **Fill to full:** `DEPTH` = 16; write 0x00..0x0F → `full` = 1 and count = 16. `almost_full` rises on the 14th write. A 17th write sets `overflow` and the contents are unchanged. Then read 16 words → 0x00..0x0F in order, each with `dout_valid`; `empty` = 1 after the last.
- **Underflow:** read while empty → `underflow` = 1, `dout_valid` = 0, count stays 0. Then assert `clr` for one cycle → `underflow` = 0.
- **Simultaneous read/write:**
  - Preload 3 words, then assert `wr` and `rd` together for 20 cycles with an incrementing `din` → count stays 3 and output is in order across pointer wrap.
  - Full with both asserted → count = 15, `overflow` = 1.
  - Empty with both asserted → count = 1, `underflow` = 1.
- **Flush:** with 7 words stored, assert `clr` together with `wr` → count = 0 and `empty` = 1 on the next edge; the write is dropped. A following write/read returns only the new data.
- **Parameter sweep:** `DATA_W` = 32, `DEPTH` = 4, `AF_LEVEL` = 3, `AE_LEVEL` = 1 → random traffic matches a scoreboard model, and all flags match the count decode every cycle.
